// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues word-aligned fetches under a credit limit,
// pairs in-order responses with their addresses and buffers them for decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_drop_cnt;
  logic [31:0]   r_pend_addr [DEPTH];
  logic [PW-1:0] r_pend_wr;
  logic [PW-1:0] r_pend_rd;
  logic [31:0]   r_buf_pc    [DEPTH];
  logic [31:0]   r_buf_instr [DEPTH];
  logic [PW-1:0] r_buf_wr;
  logic [PW-1:0] r_buf_rd;
  logic [CW-1:0] r_buf_cnt;

  logic          w_if_valid;
  logic          w_pop;
  logic [CW-1:0] w_pop_c;
  logic [CW-1:0] w_buf_after_pop;
  logic          w_req_valid;
  logic          w_req_fire;
  logic [CW-1:0] w_req_c;
  logic          w_rsp_live;
  logic [CW-1:0] w_rsp_c;
  logic          w_push;
  logic [CW-1:0] w_push_c;
  logic          w_unused_lsb;

  assign w_if_valid = !rst && (r_buf_cnt != '0) && !redirect_valid;
  assign w_pop      = w_if_valid && if_ready;
  assign w_pop_c    = {{(CW-1){1'b0}}, w_pop};

  // Credit counts the buffer after this cycle's pop so a draining buffer
  // keeps back-to-back fetch going; a push can only come from a credited slot.
  assign w_buf_after_pop = r_buf_cnt - w_pop_c;
  assign w_req_valid     = !rst && !redirect_valid && ((r_out_cnt + w_buf_after_pop) < DEPTH_C);
  assign w_req_fire      = w_req_valid && imem_req_ready;
  assign w_req_c         = {{(CW-1){1'b0}}, w_req_fire};

  // Responses with nothing outstanding are stray and ignored entirely.
  assign w_rsp_live = !rst && imem_rsp_valid && (r_out_cnt != '0);
  assign w_rsp_c    = {{(CW-1){1'b0}}, w_rsp_live};
  assign w_push     = w_rsp_live && !redirect_valid && (r_drop_cnt == '0);
  assign w_push_c   = {{(CW-1){1'b0}}, w_push};

  assign w_unused_lsb = ^redirect_pc[1:0];

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign if_valid       = w_if_valid;
  assign if_instr       = w_if_valid ? r_buf_instr[r_buf_rd] : NOP;
  assign if_pc          = w_if_valid ? r_buf_pc[r_buf_rd]    : 32'h00000000;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
      r_pend_wr  <= '0;
      r_pend_rd  <= '0;
      r_buf_wr   <= '0;
      r_buf_rd   <= '0;
      r_buf_cnt  <= '0;
    end else begin
      r_out_cnt <= r_out_cnt + w_req_c - w_rsp_c;
      if (redirect_valid) begin
        // Everything still in flight belongs to the old path and must be dropped.
        r_pc       <= {redirect_pc[31:2], 2'b00};
        r_drop_cnt <= r_out_cnt - w_rsp_c;
        r_pend_wr  <= '0;
        r_pend_rd  <= '0;
        r_buf_wr   <= '0;
        r_buf_rd   <= '0;
        r_buf_cnt  <= '0;
      end else begin
        if (w_req_fire) begin
          r_pc      <= r_pc + 32'd4;
          r_pend_wr <= r_pend_wr + PW'(1);
        end
        if (w_rsp_live && (r_drop_cnt != '0)) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
        if (w_push) begin
          r_buf_wr  <= r_buf_wr + PW'(1);
          r_pend_rd <= r_pend_rd + PW'(1);
        end
        if (w_pop) begin
          r_buf_rd <= r_buf_rd + PW'(1);
        end
        r_buf_cnt <= r_buf_cnt + w_push_c - w_pop_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_pend_addr[r_pend_wr] <= r_pc;
    end
    if (w_push) begin
      r_buf_pc[r_buf_wr]    <= r_pend_addr[r_pend_rd];
      r_buf_instr[r_buf_wr] <= imem_rsp_data;
    end
  end

endmodule
